raizing_gfx_arbiter: RTL and testbench

- Shares one graphics-ROM SDRAM slot (22-bit address, 32-bit data) between four tile fetchers: OBJ (ch0) and SCR0/SCR1/SCR2 (ch1..3).
- Sits between the GCU tile-fetch ports and the SDRAM controller, so a board variant can use one ROM bank instead of four.
- Each channel keeps a one-entry last-fetch latch, so repeat requests hit without a ROM access.
- Arbitration is round-robin. The ROM port uses a CS/OK handshake.

---
 rtl/raizing_gfx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_raizing_gfx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raizing_gfx_arbiter.sv
// Round-robin share of one graphics-ROM slot between four tile fetchers.
// Optional OBJ priority: define RAIZING_GFXARB_OBJPRIO_EN.
module raizing_gfx_arbiter #(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CS0,
    input  logic          CS1,
    input  logic          CS2,
    input  logic          CS3,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [AW-1:0] ADDR2,
    input  logic [AW-1:0] ADDR3,
    output logic          OK0,
    output logic          OK1,
    output logic          OK2,
    output logic          OK3,
    output logic [DW-1:0] DATA0,
    output logic [DW-1:0] DATA1,
    output logic [DW-1:0] DATA2,
    output logic [DW-1:0] DATA3,
    output logic          ROM_CS,
    output logic [AW-1:0] ROM_ADDR,
    input  logic          ROM_OK,
    input  logic [DW-1:0] ROM_DOUT,
    output logic [1:0]    GNT,
    output logic          ERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_valid;
    logic [AW-1:0]   r_laddr [4];
    logic [DW-1:0]   r_ldata [4];
    logic            r_rom_cs;
    logic [AW-1:0]   r_rom_addr;
    logic [1:0]      r_gnt;
    logic [1:0]      r_ptr;
    logic            r_err;
    logic            r_first;
    logic [CW-1:0]   r_cnt;

    logic [3:0]      w_cs;
    logic [AW-1:0]   w_addr [4];
    logic [3:0]      w_hit;
    logic [3:0]      w_pend;
    logic [3:0]      w_cand;
    logic [1:0]      w_sel;
    logic            w_any;
    logic            w_done;
    logic            w_tmo;

    assign w_cs      = {CS3, CS2, CS1, CS0};
    assign w_addr[0] = ADDR0;
    assign w_addr[1] = ADDR1;
    assign w_addr[2] = ADDR2;
    assign w_addr[3] = ADDR3;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 4; i++)
            w_hit[i] = r_valid[i] && (w_addr[i] == r_laddr[i]);
    end

    assign w_pend = w_cs & ~w_hit;

`ifdef RAIZING_GFXARB_OBJPRIO_EN
    assign w_cand = w_pend[0] ? 4'b0001 : (w_pend & 4'b1110);
`else
    assign w_cand = w_pend;
`endif

    // Scan PTR+1 .. PTR+4 so the last winner has lowest priority.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_any && w_cand[r_ptr + 2'(i)]) begin
                w_sel = r_ptr + 2'(i);
                w_any = 1'b1;
            end
        end
    end

    // OK may be stale from the previous address on the first BUSY cycle.
    assign w_done = (r_state == S_BUSY) && !r_first && ROM_OK;
    assign w_tmo  = (TIMEOUT != 0) && (r_state == S_BUSY) && !w_done
                    && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_BUSY;
            S_BUSY:  if (w_done || w_tmo) w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid    <= '0;
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_err      <= 1'b0;
            r_first    <= 1'b0;
            r_cnt      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_laddr[i] <= '0;
                r_ldata[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_rom_cs <= w_any;
                    if (w_any) begin
                        r_rom_addr <= w_addr[w_sel];
                        r_gnt      <= w_sel;
                        r_cnt      <= '0;
                        r_first    <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_first <= 1'b0;
                    if (w_done) begin
                        r_ldata[r_gnt] <= ROM_DOUT;
                        r_laddr[r_gnt] <= r_rom_addr;
                        r_valid[r_gnt] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (w_tmo) r_err <= 1'b1;
                    end
                    if (w_done || w_tmo) begin
                        r_rom_cs <= 1'b0;
`ifdef RAIZING_GFXARB_OBJPRIO_EN
                        if (r_gnt != 2'd0) r_ptr <= r_gnt;
`else
                        r_ptr <= r_gnt;
`endif
                    end
                end
                default: r_rom_cs <= 1'b0;
            endcase
        end
    end

    assign OK0      = w_cs[0] & w_hit[0];
    assign OK1      = w_cs[1] & w_hit[1];
    assign OK2      = w_cs[2] & w_hit[2];
    assign OK3      = w_cs[3] & w_hit[3];
    assign DATA0    = r_ldata[0];
    assign DATA1    = r_ldata[1];
    assign DATA2    = r_ldata[2];
    assign DATA3    = r_ldata[3];
    assign ROM_CS   = r_rom_cs;
    assign ROM_ADDR = r_rom_addr;
    assign GNT      = r_gnt;
    assign ERR      = r_err;

endmodule

// File: tb/tb_raizing_gfx_arbiter.sv
// Bench for raizing_gfx_arbiter: grant scoreboard plus directed checks.
// Covers hit/miss, rotation, address change, watchdog and reset abort.
module tb_raizing_gfx_arbiter;

    logic        CLK = 0;
    logic        RESET = 1;
    logic        CS0 = 0, CS1 = 0, CS2 = 0, CS3 = 0;
    logic [21:0] ADDR0 = 0, ADDR1 = 0, ADDR2 = 0, ADDR3 = 0;
    logic        OK0, OK1, OK2, OK3;
    logic [31:0] DATA0, DATA1, DATA2, DATA3;
    logic        ROM_CS;
    logic [21:0] ROM_ADDR;
    logic        ROM_OK;
    logic [31:0] ROM_DOUT;
    logic [1:0]  GNT;
    logic        ERR;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  g;
        logic [21:0] a;
    } grant_t;
    grant_t exp_q[$];

    logic rom_const = 0;
    logic rom_en    = 1;
    int   rom_lat   = 3;
    int   bc        = 0;
    logic rom_pulse = 0;

    raizing_gfx_arbiter #(.AW(22), .DW(32), .TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .CS0(CS0), .CS1(CS1), .CS2(CS2), .CS3(CS3),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2), .ADDR3(ADDR3),
        .OK0(OK0), .OK1(OK1), .OK2(OK2), .OK3(OK3),
        .DATA0(DATA0), .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3),
        .ROM_CS(ROM_CS), .ROM_ADDR(ROM_ADDR),
        .ROM_OK(ROM_OK), .ROM_DOUT(ROM_DOUT),
        .GNT(GNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_data(input logic [21:0] a);
        if (a == 22'h000100) return 32'hDEADBEEF;
        return {10'h2A5, a};
    endfunction

    assign ROM_DOUT = rom_data(ROM_ADDR);
    assign ROM_OK   = rom_const | rom_pulse;

    // ROM model: OK pulses on BUSY cycle number rom_lat.
    always @(posedge CLK) begin
        #1;
        if (ROM_CS) bc = bc + 1;
        else        bc = 0;
        rom_pulse = rom_en && ROM_CS && (bc == rom_lat);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new ROM request must match the next expected grant.
    logic prev_cs = 0;
    always @(posedge CLK) begin
        #2;
        if (ROM_CS && !prev_cs) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", {8'h0, GNT, ROM_ADDR}, 32'hFFFFFFFF);
            end else begin
                grant_t e;
                e = exp_q.pop_front();
                chk("grant_chan", {30'h0, GNT}, {30'h0, e.g});
                chk("grant_addr", {10'h0, ROM_ADDR}, {10'h0, e.a});
            end
        end
        prev_cs = ROM_CS;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1;
        {CS0, CS1, CS2, CS3} = '0;
        rom_const = 0;
        rom_en    = 1;
        tick();
        tick();
        RESET = 0;
    endtask

    function automatic grant_t mk(input logic [1:0] g, input logic [21:0] a);
        grant_t r;
        r.g = g;
        r.a = a;
        return r;
    endfunction

    initial begin
        int n;
        int hi;
        logic seen;

        // Reset state and single miss followed by a hit
        do_reset();
        chk("rst_rom_cs", {31'h0, ROM_CS}, 0);
        chk("rst_gnt", {30'h0, GNT}, 0);
        chk("rst_err", {31'h0, ERR}, 0);
        chk("rst_data1", DATA1, 0);
        rom_lat = 3;
        CS1 = 1;
        ADDR1 = 22'h000100;
        exp_q.push_back(mk(2'd1, 22'h000100));
        chk("ok1_before", {31'h0, OK1}, 0);
        tick();
        chk("rom_cs_lat1", {31'h0, ROM_CS}, 1);
        n = 0;
        while (!OK1 && n < 20) begin
            tick();
            n++;
        end
        chk("ok1_latency", n, 3);
        chk("data1", DATA1, 32'hDEADBEEF);
        chk("gap_rom_cs", {31'h0, ROM_CS}, 0);
        CS1 = 0;
        tick();
        CS1 = 1;
        #1;
        chk("ok1_hit", {31'h0, OK1}, 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= ROM_CS;
        end
        chk("hit_no_rom_cs", {31'h0, seen}, 0);

        // Four-way rotation with ROM_OK constantly high
        do_reset();
        rom_const = 1;
        ADDR0 = 22'h001000; ADDR1 = 22'h001001;
        ADDR2 = 22'h001002; ADDR3 = 22'h001003;
        exp_q.push_back(mk(2'd1, 22'h001001));
        exp_q.push_back(mk(2'd2, 22'h001002));
        exp_q.push_back(mk(2'd3, 22'h001003));
        exp_q.push_back(mk(2'd0, 22'h001000));
        {CS0, CS1, CS2, CS3} = 4'hF;
        n = 0;
        hi = 0;
        while (!(OK0 && OK1 && OK2 && OK3) && n < 40) begin
            tick();
            n++;
            if (ROM_CS) hi++;
        end
        chk("rr_cycles", n, 15);
        chk("rr_busy_cycles", hi, 8);
        chk("rr_data0", DATA0, rom_data(22'h001000));
        chk("rr_data3", DATA3, rom_data(22'h001003));

        // Address change during BUSY
        do_reset();
        rom_lat = 3;
        CS2 = 1;
        ADDR2 = 22'h000010;
        exp_q.push_back(mk(2'd2, 22'h000010));
        exp_q.push_back(mk(2'd2, 22'h000020));
        tick();
        tick();
        ADDR2 = 22'h000020;
        tick();
        chk("chg_ok2_busy", {31'h0, OK2}, 0);
        tick();
        chk("chg_ok2_gap", {31'h0, OK2}, 0);
        chk("chg_data_old", DATA2, rom_data(22'h000010));
        n = 0;
        while (!OK2 && n < 20) begin
            tick();
            n++;
        end
        chk("chg_ok2_new", {31'h0, OK2}, 1);
        chk("chg_data_new", DATA2, rom_data(22'h000020));
        ADDR2 = 22'h000010;
        #1;
        chk("chg_ok2_comb_drop", {31'h0, OK2}, 0);

        // Watchdog timeout, then normal service
        do_reset();
        rom_en = 0;
        CS3 = 1;
        ADDR3 = 22'h000300;
        exp_q.push_back(mk(2'd3, 22'h000300));
        tick();
        n = 0;
        while (ROM_CS && n < 30) begin
            n++;
            tick();
        end
        chk("tmo_busy_cycles", n, 8);
        chk("tmo_err", {31'h0, ERR}, 1);
        chk("tmo_ok3", {31'h0, OK3}, 0);
        rom_en = 1;
        rom_lat = 2;
        exp_q.push_back(mk(2'd3, 22'h000300));
        n = 0;
        while (!OK3 && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_recover_ok3", {31'h0, OK3}, 1);
        chk("tmo_recover_data", DATA3, rom_data(22'h000300));
        chk("tmo_err_sticky", {31'h0, ERR}, 1);

        // Reset during the second BUSY cycle
        CS3 = 0;
        rom_lat = 3;
        CS1 = 1;
        ADDR1 = 22'h000500;
        exp_q.push_back(mk(2'd1, 22'h000500));
        tick();
        tick();
        tick();
        chk("abort_in_busy", {31'h0, ROM_CS}, 1);
        RESET = 1;
        tick();
        chk("abort_rom_cs", {31'h0, ROM_CS}, 0);
        chk("abort_err", {31'h0, ERR}, 0);
        chk("abort_ok1", {31'h0, OK1}, 0);
        chk("abort_data1", DATA1, 0);
        chk("abort_ok3", {31'h0, OK3}, 0);
        exp_q.push_back(mk(2'd1, 22'h000500));
        RESET = 0;
        n = 0;
        while (!OK1 && n < 20) begin
            tick();
            n++;
        end
        chk("abort_retry_data", DATA1, rom_data(22'h000500));

`ifdef RAIZING_GFXARB_OBJPRIO_EN
        // OBJ priority: ch0 re-pends after every grant to another channel
        do_reset();
        rom_const = 1;
        ADDR0 = 22'h002000; ADDR1 = 22'h002001;
        ADDR2 = 22'h002002; ADDR3 = 22'h002003;
        exp_q.push_back(mk(2'd0, 22'h002000));
        exp_q.push_back(mk(2'd1, 22'h002001));
        exp_q.push_back(mk(2'd0, 22'h002010));
        exp_q.push_back(mk(2'd2, 22'h002002));
        exp_q.push_back(mk(2'd0, 22'h002020));
        exp_q.push_back(mk(2'd3, 22'h002003));
        exp_q.push_back(mk(2'd0, 22'h002030));
        {CS0, CS1, CS2, CS3} = 4'hF;
        seen = 0;
        n = 0;
        while (!(OK0 && OK1 && OK2 && OK3) && n < 60) begin
            tick();
            n++;
            if (ROM_CS && !seen && GNT != 2'd0) ADDR0 = ADDR0 + 22'h10;
            seen = ROM_CS;
        end
        chk("prio_all_ok", {28'h0, OK3, OK2, OK1, OK0}, 32'hF);
`endif

        tick();
        tick();
        chk("grant_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
